// File: rtl/systolic_pe.sv
// Weight-stationary systolic-array processing element: one stationary weight, one MAC per clock.
// Optional build macro PE_SATURATE_EN makes the partial-sum output saturate instead of wrapping.
module systolic_pe #(
    parameter int Data_width = 8
) (
    input  logic                  iClk,
    input  logic                  iRest_n,
    input  logic                  enable_w,
    input  logic                  Run,
    input  logic [Data_width-1:0] Weight_f_top,
    input  logic [Data_width-1:0] Psum_f_top,
    input  logic [Data_width-1:0] Ifmap_f_left,
    output logic [Data_width-1:0] Ifmap_t_right,
    output logic [Data_width-1:0] Psum_t_down
);

    localparam int W = Data_width;

    // The carry bit above the full product is kept so saturation can see any overflow.
    function automatic logic [W-1:0] reduce_sum(input logic [2*W:0] sum);
        logic [W-1:0] result;
`ifdef PE_SATURATE_EN
        if (|sum[2*W:W]) begin
            result = {W{1'b1}};
        end else begin
            result = sum[W-1:0];
        end
`else
        result = sum[W-1:0];
`endif
        return result;
    endfunction

    logic [W-1:0]   weight_q, weight_d;
    logic [W-1:0]   ifmap_q,  ifmap_d;
    logic [W-1:0]   psum_q,   psum_d;
    logic [2*W-1:0] product_s;
    logic [2*W:0]   sum_s;

    // MAC uses the weight held before this edge, so a same-edge load only affects the next MAC.
    always_comb begin
        product_s = {{W{1'b0}}, weight_q} * {{W{1'b0}}, Ifmap_f_left};
        sum_s     = {1'b0, product_s} + {{(W + 1){1'b0}}, Psum_f_top};

        if (enable_w) begin
            weight_d = Weight_f_top;
        end else begin
            weight_d = weight_q;
        end

        if (Run) begin
            ifmap_d = Ifmap_f_left;
            psum_d  = reduce_sum(sum_s);
        end else begin
            ifmap_d = ifmap_q;
            psum_d  = psum_q;
        end
    end

    // State registers; reset clears the weight too, so it must be reloaded afterwards.
    always_ff @(posedge iClk or negedge iRest_n) begin
        if (!iRest_n) begin
            weight_q <= {W{1'b0}};
            ifmap_q  <= {W{1'b0}};
            psum_q   <= {W{1'b0}};
        end else begin
            weight_q <= weight_d;
            ifmap_q  <= ifmap_d;
            psum_q   <= psum_d;
        end
    end

    assign Ifmap_t_right = ifmap_q;
    assign Psum_t_down   = psum_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed self-checking bench for systolic_pe (Data_width = 8), one task per scenario.
module tb_systolic_pe;

    logic       iClk = 1'b0;
    logic       iRest_n;
    logic       enable_w;
    logic       Run;
    logic [7:0] Weight_f_top;
    logic [7:0] Psum_f_top;
    logic [7:0] Ifmap_f_left;
    logic [7:0] Ifmap_t_right;
    logic [7:0] Psum_t_down;

    int total = 0;
    int bad   = 0;

    systolic_pe #(.Data_width(8)) dut (
        .iClk         (iClk),
        .iRest_n      (iRest_n),
        .enable_w     (enable_w),
        .Run          (Run),
        .Weight_f_top (Weight_f_top),
        .Psum_f_top   (Psum_f_top),
        .Ifmap_f_left (Ifmap_f_left),
        .Ifmap_t_right(Ifmap_t_right),
        .Psum_t_down  (Psum_t_down)
    );

    always #5 iClk = ~iClk;

    // Advance past the next rising edge; outputs are sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic load_weight(input logic [7:0] w);
        Run = 1'b0; enable_w = 1'b1; Weight_f_top = w;
        step();
        enable_w = 1'b0;
    endtask

    task automatic test_reset();
        iRest_n = 1'b0; Run = 1'b1; enable_w = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Weight_f_top = 8'($urandom); Psum_f_top = 8'($urandom); Ifmap_f_left = 8'($urandom);
            step();
            total++;
            if (Ifmap_t_right !== 8'd0) begin
                bad++; $display("FAIL reset_ifmap cycle %0d: got %0d want 0", i, Ifmap_t_right);
            end
            total++;
            if (Psum_t_down !== 8'd0) begin
                bad++; $display("FAIL reset_psum cycle %0d: got %0d want 0", i, Psum_t_down);
            end
        end
    endtask

    task automatic test_load_then_run();
        Weight_f_top = 8'd5; Ifmap_f_left = 8'd4; Psum_f_top = 8'd0;
        enable_w = 1'b1; Run = 1'b1;
        iRest_n = 1'b1;
        step();
        total++;
        if (Psum_t_down !== 8'd0) begin
            bad++; $display("FAIL load_run_first_psum: got %0d want 0", Psum_t_down);
        end
        total++;
        if (Ifmap_t_right !== 8'd4) begin
            bad++; $display("FAIL load_run_first_ifmap: got %0d want 4", Ifmap_t_right);
        end
        step();
        total++;
        if (Psum_t_down !== 8'd20) begin
            bad++; $display("FAIL load_run_second_psum: got %0d want 20", Psum_t_down);
        end
        enable_w = 1'b0;
    endtask

    task automatic test_accumulate();
        load_weight(8'd3);
        Run = 1'b1; Psum_f_top = 8'd10; Ifmap_f_left = 8'd7;
        step();
        total++;
        if (Psum_t_down !== 8'd31) begin
            bad++; $display("FAIL accumulate_psum: got %0d want 31", Psum_t_down);
        end
        total++;
        if (Ifmap_t_right !== 8'd7) begin
            bad++; $display("FAIL accumulate_ifmap: got %0d want 7", Ifmap_t_right);
        end
    endtask

    task automatic test_hold();
        Run = 1'b0; Ifmap_f_left = 8'd20; Psum_f_top = 8'd50; Weight_f_top = 8'd1;
        step();
        step();
        total++;
        if (Psum_t_down !== 8'd31) begin
            bad++; $display("FAIL hold_psum: got %0d want 31", Psum_t_down);
        end
        total++;
        if (Ifmap_t_right !== 8'd7) begin
            bad++; $display("FAIL hold_ifmap: got %0d want 7", Ifmap_t_right);
        end
        Run = 1'b1;
        step();
        total++;
        if (Psum_t_down !== 8'd110) begin
            bad++; $display("FAIL hold_resume_psum: got %0d want 110", Psum_t_down);
        end
        total++;
        if (Ifmap_t_right !== 8'd20) begin
            bad++; $display("FAIL hold_resume_ifmap: got %0d want 20", Ifmap_t_right);
        end
    endtask

    task automatic test_weight_update();
        load_weight(8'd2);
        Run = 1'b1; Ifmap_f_left = 8'd6; Psum_f_top = 8'd0;
        enable_w = 1'b1; Weight_f_top = 8'd9;
        step();
        enable_w = 1'b0;
        total++;
        if (Psum_t_down !== 8'd12) begin
            bad++; $display("FAIL weight_update_old: got %0d want 12", Psum_t_down);
        end
        step();
        total++;
        if (Psum_t_down !== 8'd54) begin
            bad++; $display("FAIL weight_update_new: got %0d want 54", Psum_t_down);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_over;
        logic [7:0] exp_max;
`ifdef PE_SATURATE_EN
        exp_over = 8'd255; exp_max = 8'd255;
`else
        exp_over = 8'd244; exp_max = 8'd0;
`endif
        load_weight(8'd200);
        Run = 1'b1; Ifmap_f_left = 8'd2; Psum_f_top = 8'd100;
        step();
        total++;
        if (Psum_t_down !== exp_over) begin
            bad++; $display("FAIL overflow_500: got %0d want %0d", Psum_t_down, exp_over);
        end
        Ifmap_f_left = 8'd1; Psum_f_top = 8'd55;
        step();
        total++;
        if (Psum_t_down !== 8'd255) begin
            bad++; $display("FAIL overflow_exact_255: got %0d want 255", Psum_t_down);
        end
        load_weight(8'd255);
        Run = 1'b1; Ifmap_f_left = 8'd255; Psum_f_top = 8'd255;
        step();
        total++;
        if (Psum_t_down !== exp_max) begin
            bad++; $display("FAIL overflow_max: got %0d want %0d", Psum_t_down, exp_max);
        end
        total++;
        if (Ifmap_t_right !== 8'd255) begin
            bad++; $display("FAIL overflow_ifmap: got %0d want 255", Ifmap_t_right);
        end
    endtask

    task automatic test_async_reset();
        #2;
        iRest_n = 1'b0;
        #1;
        total++;
        if (Psum_t_down !== 8'd0) begin
            bad++; $display("FAIL async_reset_psum: got %0d want 0", Psum_t_down);
        end
        total++;
        if (Ifmap_t_right !== 8'd0) begin
            bad++; $display("FAIL async_reset_ifmap: got %0d want 0", Ifmap_t_right);
        end
        #1;
        iRest_n = 1'b1;
        Run = 1'b1; enable_w = 1'b0; Ifmap_f_left = 8'd3; Psum_f_top = 8'd7;
        step();
        total++;
        if (Psum_t_down !== 8'd7) begin
            bad++; $display("FAIL reset_clears_weight: got %0d want 7", Psum_t_down);
        end
    endtask

    initial begin
        iRest_n = 1'b0; enable_w = 1'b0; Run = 1'b0;
        Weight_f_top = 8'd0; Psum_f_top = 8'd0; Ifmap_f_left = 8'd0;
        #1;
        test_reset();
        test_load_then_run();
        test_accumulate();
        test_hold();
        test_weight_update();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
